// File: rtl/mcu_spi.sv
// SPI target (mode 0, MSB first) bridging the board MCU to per-function byte-stream targets.
// SCK/SS/MOSI are oversampled in the core clock domain; the first byte of a transaction selects the target.
`timescale 1ns/1ps
module mcu_spi #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  TGT_SYS     = 8'd0,
    parameter logic [7:0]  TGT_HID     = 8'd1,
    parameter logic [7:0]  TGT_OSD     = 8'd2,
    parameter logic [7:0]  TGT_SDC     = 8'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_io_ss,
    input  logic       spi_io_clk,
    input  logic       spi_io_din,
    output logic       spi_io_dout,
    output logic       mcu_sys_strobe,
    output logic       mcu_hid_strobe,
    output logic       mcu_osd_strobe,
    output logic       mcu_sdc_strobe,
    output logic       mcu_start,
    output logic [7:0] mcu_dout,
    input  logic [7:0] mcu_sys_din,
    input  logic [7:0] mcu_hid_din,
    input  logic [7:0] mcu_osd_din,
    input  logic [7:0] mcu_sdc_din
);

    typedef enum logic [1:0] {StIdle, StTarget, StCmd, StData} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q, ss_prev_q;
    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic [3:0]             sel_q, sel_d;
    logic                   load_q, load_d;
    logic [7:0]             dout_q, dout_d;
    logic [3:0]             strobe_q, strobe_d;
    logic                   start_q, start_d;

    logic       sck_s, ss_s, mosi_s;
    logic       sck_rise, sck_fall, ss_fall, byte_done;
    logic [7:0] rx_byte, reply;
    logic [3:0] tgt_hit;

    // SS chain resets to 0 (active) so a transfer already in progress at reset
    // release is ignored until SS is seen high and then low again.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_io_clk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_io_ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_io_din};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign ss_fall   = ss_prev_q & ~ss_s;
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_q[6:0], mosi_s};

    assign tgt_hit = {rx_byte == TGT_SDC, rx_byte == TGT_OSD,
                      rx_byte == TGT_HID, rx_byte == TGT_SYS};

    always_comb begin
        reply = 8'h00;
        if (sel_q[0])      reply = mcu_sys_din;
        else if (sel_q[1]) reply = mcu_hid_din;
        else if (sel_q[2]) reply = mcu_osd_din;
        else if (sel_q[3]) reply = mcu_sdc_din;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        sel_d     = sel_q;
        load_d    = load_q;
        dout_d    = dout_q;
        strobe_d  = 4'b0000;
        start_d   = 1'b0;

        if (ss_s) begin
            state_d   = StIdle;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
            load_d    = 1'b0;
        end else if (state_q == StIdle) begin
            if (ss_fall) begin
                state_d   = StTarget;
                bit_cnt_d = 3'd0;
                rx_d      = 8'h00;
                tx_d      = 8'h00;
            end
        end else begin
            if (sck_rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                load_d = 1'b1;
                unique case (state_q)
                    StTarget: begin
                        sel_d   = tgt_hit;
                        state_d = StCmd;
                    end
                    StCmd: begin
                        dout_d   = rx_byte;
                        strobe_d = sel_q;
                        start_d  = |sel_q;
                        state_d  = StData;
                    end
                    default: begin
                        dout_d   = rx_byte;
                        strobe_d = sel_q;
                    end
                endcase
            end
            // First falling edge after a byte loads the reply; the target byte has none.
            if (sck_fall) begin
                if (load_q) begin
                    load_d = 1'b0;
                    tx_d   = (state_q == StCmd) ? 8'h00 : reply;
                end else if (state_q == StTarget) begin
                    tx_d = 8'h00;
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            sel_q     <= 4'b0000;
            load_q    <= 1'b0;
            dout_q    <= 8'h00;
            strobe_q  <= 4'b0000;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            sel_q     <= sel_d;
            load_q    <= load_d;
            dout_q    <= dout_d;
            strobe_q  <= strobe_d;
            start_q   <= start_d;
        end
    end

    assign spi_io_dout    = tx_q[7];
    assign mcu_sys_strobe = strobe_q[0];
    assign mcu_hid_strobe = strobe_q[1];
    assign mcu_osd_strobe = strobe_q[2];
    assign mcu_sdc_strobe = strobe_q[3];
    assign mcu_start      = start_q;
    assign mcu_dout       = dout_q;

endmodule

// File: tb/tb_mcu_spi.sv
// Self-checking bench for mcu_spi: table-driven transactions, hand-written abort/reset sequences,
// clock-ratio sweep and randomized transactions checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mcu_spi;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_io_ss, spi_io_clk, spi_io_din, spi_io_dout;
    logic       sys_stb, hid_stb, osd_stb, sdc_stb, mcu_start;
    logic [7:0] mcu_dout;
    logic [7:0] tdin [4];
    int         tidx [4];
    logic [7:0] reply_seq [8];

    always #5 clk = ~clk;

    mcu_spi #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_io_ss      (spi_io_ss),
        .spi_io_clk     (spi_io_clk),
        .spi_io_din     (spi_io_din),
        .spi_io_dout    (spi_io_dout),
        .mcu_sys_strobe (sys_stb),
        .mcu_hid_strobe (hid_stb),
        .mcu_osd_strobe (osd_stb),
        .mcu_sdc_strobe (sdc_stb),
        .mcu_start      (mcu_start),
        .mcu_dout       (mcu_dout),
        .mcu_sys_din    (tdin[0]),
        .mcu_hid_din    (tdin[1]),
        .mcu_osd_din    (tdin[2]),
        .mcu_sdc_din    (tdin[3])
    );

    logic [3:0] stb_vec;
    assign stb_vec = {sdc_stb, osd_stb, hid_stb, sys_stb};

    // Model targets: reply 00 to a command byte, then walk reply_seq, one step per strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                tdin[i] <= 8'h00;
                tidx[i] <= 0;
            end else if (stb_vec[i]) begin
                if (mcu_start) begin
                    tdin[i] <= 8'h00;
                    tidx[i] <= 0;
                end else begin
                    tdin[i] <= reply_seq[tidx[i] % 8];
                    tidx[i] <= tidx[i] + 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0] sel;
        logic       start;
        logic [7:0] dout;
    } ev_t;
    ev_t log_q[$];

    always @(negedge clk) begin
        if (stb_vec != 4'b0000 || mcu_start) log_q.push_back({stb_vec, mcu_start, mcu_dout});
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [7:0] t);
        case (t)
            8'd0:    return 4'b0001;
            8'd1:    return 4'b0010;
            8'd2:    return 4'b0100;
            8'd3:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    logic [7:0] xb [8];
    int         xn;
    logic [7:0] miso_got [8];
    logic [7:0] rxb;

    task automatic send_bits(input logic [7:0] b, input int first, input int last, input int half);
        for (int i = first; i <= last; i++) begin
            spi_io_din = b[7-i];
            #(half);
            rxb[7-i] = spi_io_dout;
            spi_io_clk = 1'b1;
            #(half);
            spi_io_clk = 1'b0;
        end
    endtask

    // Keep SPI edges off the clk edges, with a random phase.
    task automatic align();
        @(posedge clk);
        #($urandom_range(1, 4));
    endtask

    task automatic run_xfer(input int half);
        align();
        spi_io_ss = 1'b0;
        for (int k = 0; k < xn; k++) begin
            rxb = 8'h00;
            send_bits(xb[k], 0, 7, half);
            miso_got[k] = rxb;
        end
        #(half);
        spi_io_ss = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    // Transaction-level expectation: byte 0 selects, byte 1 is the command (start),
    // reply to byte k appears on MISO during byte k+1.
    task automatic check_xfer(input string tag, input logic [3:0] exp_sel, input int exp_n);
        ev_t        ev;
        logic [7:0] em;
        chk($sformatf("%s strobe_count", tag), log_q.size(), exp_n);
        if (exp_sel != 4'b0000) begin
            for (int k = 1; k < xn; k++) begin
                if (k - 1 < log_q.size()) begin
                    ev = log_q[k-1];
                    chk($sformatf("%s sel[%0d]", tag, k), {28'd0, ev.sel}, {28'd0, exp_sel});
                    chk($sformatf("%s start[%0d]", tag, k), {31'd0, ev.start}, (k == 1) ? 1 : 0);
                    chk($sformatf("%s dout[%0d]", tag, k), {24'd0, ev.dout}, {24'd0, xb[k]});
                end
            end
        end
        for (int k = 0; k < xn; k++) begin
            em = (exp_sel == 4'b0000 || k < 3) ? 8'h00 : reply_seq[k-3];
            chk($sformatf("%s miso[%0d]", tag, k), {24'd0, miso_got[k]}, {24'd0, em});
        end
        log_q.delete();
    endtask

    typedef struct {
        logic [7:0]  tgt;
        logic [31:0] pay;
        int          npay;
        logic [3:0]  exp_sel;
        int          exp_n;
    } vec_t;
    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int half;
        int r;
        int ratios [3];

        vecs[0] = '{tgt: 8'h00, pay: 32'h0103_0000, npay: 2, exp_sel: 4'b0001, exp_n: 2};
        vecs[1] = '{tgt: 8'h07, pay: 32'hDEAD_BEEF, npay: 4, exp_sel: 4'b0000, exp_n: 0};
        vecs[2] = '{tgt: 8'h01, pay: 32'h4041_4200, npay: 3, exp_sel: 4'b0010, exp_n: 3};
        vecs[3] = '{tgt: 8'h02, pay: 32'h5566_0000, npay: 2, exp_sel: 4'b0100, exp_n: 2};
        vecs[4] = '{tgt: 8'h03, pay: 32'h7788_99AA, npay: 4, exp_sel: 4'b1000, exp_n: 4};
        vecs[5] = '{tgt: 8'h00, pay: 32'h0000_0000, npay: 4, exp_sel: 4'b0001, exp_n: 4};
        ratios[0] = 8; ratios[1] = 9; ratios[2] = 16;

        reset = 1'b1; spi_io_ss = 1'b1; spi_io_clk = 1'b0; spi_io_din = 1'b0;
        reply_seq[0] = 8'h5C; reply_seq[1] = 8'h42; reply_seq[2] = 8'h13; reply_seq[3] = 8'h37;
        for (int i = 4; i < 8; i++) reply_seq[i] = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset strobes", {28'd0, stb_vec}, 0);
        chk("reset start", {31'd0, mcu_start}, 0);
        chk("reset dout", {24'd0, mcu_dout}, 0);
        chk("reset miso", {31'd0, spi_io_dout}, 0);
        repeat (5) @(posedge clk);
        log_q.delete();

        // Table: select, command/data strobes, unknown target, reply stream
        for (int v = 0; v < 6; v++) begin
            xb[0] = vecs[v].tgt;
            for (int j = 0; j < vecs[v].npay; j++) xb[j+1] = vecs[v].pay[31-8*j -: 8];
            xn = vecs[v].npay + 1;
            run_xfer(40);
            check_xfer($sformatf("vec%0d", v), vecs[v].exp_sel, vecs[v].exp_n);
        end
        chk("reply_stream byte3", {24'd0, miso_got[3]}, 32'h5C);
        chk("reply_stream byte4", {24'd0, miso_got[4]}, 32'h42);

        // Abort after 5 bits of the command byte
        align();
        spi_io_ss = 1'b0;
        send_bits(8'h02, 0, 7, 40);
        send_bits(8'h99, 0, 4, 40);
        #40;
        spi_io_ss = 1'b1;
        repeat (10) @(posedge clk);
        chk("abort no_strobe", log_q.size(), 0);
        log_q.delete();
        xb[0] = 8'h02; xb[1] = 8'hAA; xn = 2;
        run_xfer(40);
        check_xfer("after_abort", 4'b0100, 1);

        // Reset in the middle of the third byte
        align();
        spi_io_ss = 1'b0;
        send_bits(8'h01, 0, 7, 40);
        send_bits(8'h11, 0, 7, 40);
        send_bits(8'hC3, 0, 2, 40);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset strobes", {28'd0, stb_vec}, 0);
        chk("midreset start", {31'd0, mcu_start}, 0);
        chk("midreset dout", {24'd0, mcu_dout}, 0);
        chk("midreset miso", {31'd0, spi_io_dout}, 0);
        chk("midreset prior_strobes", log_q.size(), 1);
        log_q.delete();
        send_bits(8'hC3, 3, 7, 40);
        send_bits(8'h01, 0, 7, 40);
        send_bits(8'h55, 0, 7, 40);
        repeat (10) @(posedge clk);
        chk("midreset no_strobe", log_q.size(), 0);
        spi_io_ss = 1'b1;
        repeat (10) @(posedge clk);
        log_q.delete();
        xb[0] = 8'h01; xb[1] = 8'h22; xn = 2;
        run_xfer(40);
        check_xfer("after_reset", 4'b0010, 1);

        // clk:SCK ratio sweep with byte 0x5A and reply 0xA5
        reply_seq[0] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            xb[0] = 8'h00; xb[1] = 8'h10; xb[2] = 8'h5A; xb[3] = 8'h00; xn = 4;
            run_xfer(ratios[i] * 5);
            chk($sformatf("ratio%0d reply", ratios[i]), {24'd0, miso_got[3]}, 32'hA5);
            check_xfer($sformatf("ratio%0d", ratios[i]), 4'b0001, 3);
        end

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            r = $urandom_range(0, 2);
            half = ratios[r] * 5;
            r = $urandom_range(0, 5);
            xb[0] = (r < 4) ? 8'(r) : 8'(4 + $urandom_range(0, 250));
            xn = $urandom_range(2, 6);
            for (int k = 1; k < xn; k++) xb[k] = 8'($urandom);
            for (int k = 0; k < 8; k++) reply_seq[k] = 8'($urandom);
            run_xfer(half);
            check_xfer($sformatf("rand%0d", t), onehot(xb[0]),
                       (onehot(xb[0]) != 4'b0000) ? xn - 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mcu_spi.md
Name: mcu_spi

Overview:
- SPI target (mode 0, MSB first) between the board MCU and the per-function byte-stream targets: system control, HID, OSD and SD card.
- Oversamples the MCU's SPI lines in the core clock domain and deserialises bytes.
- The first byte of each transaction selects the target. Every later byte is forwarded as a one-cycle strobe.
- The selected target's reply byte is shifted back to the MCU on MISO.

Parameters:
SYNC_STAGES, 2, flip-flop stages on the SCK, SS and MOSI inputs (minimum 2)
TGT_SYS, 8'd0, target-select value for system control
TGT_HID, 8'd1, target-select value for HID
TGT_OSD, 8'd2, target-select value for OSD
TGT_SDC, 8'd3, target-select value for SD card

Ports:
clk  in  1  core clock; must be at least 8x the SPI SCK rate
reset  in  1  synchronous, active-high
spi_io_ss  in  1  MCU chip select, active low
spi_io_clk  in  1  SPI SCK, asynchronous to clk
spi_io_din  in  1  MOSI
spi_io_dout  out  1  MISO
mcu_sys_strobe  out  1  byte-valid pulse to system control
mcu_hid_strobe  out  1  byte-valid pulse to HID
mcu_osd_strobe  out  1  byte-valid pulse to OSD
mcu_sdc_strobe  out  1  byte-valid pulse to SD card
mcu_start  out  1  marks the first byte after target selection (the command byte)
mcu_dout  out  8  received byte, shared by all targets
mcu_sys_din  in  8  reply byte from system control
mcu_hid_din  in  8  reply byte from HID
mcu_osd_din  in  8  reply byte from OSD
mcu_sdc_din  in  8  reply byte from SD card

Behaviour:
- Reset values: all strobes 0, mcu_start 0, mcu_dout 8'h00, spi_io_dout 0, state IDLE, bit counter 0, target register invalid.
- Input conditioning:
  - SCK, SS and MOSI each pass through SYNC_STAGES flip-flops.
  - Edges are detected on synchronised SCK using one extra delayed copy.
  - Rising edge: sample MOSI into the receive shift register and increment the 3-bit bit counter.
  - Falling edge: shift the transmit register; spi_io_dout always equals tx[7].
- SS inactive (high, synchronised), in any state:
  - State returns to IDLE; bit counter and rx are cleared.
  - A partial byte is discarded and no strobe is issued.
  - tx is cleared to 0.
- State machine:
  - IDLE -> TARGET on synchronised SS going low.
  - TARGET: on byte completion (8th rising edge), latch the byte as the target id, then go to CMD. No strobe is issued.
  - CMD: on byte completion, mcu_dout <= byte, pulse the selected strobe together with mcu_start = 1, then go to DATA.
  - DATA: on each byte completion, mcu_dout <= byte, pulse the selected strobe with mcu_start = 0, and stay in DATA.
- Strobe timing:
  - Strobe and mcu_start are high for exactly one clk, in the cycle after the cycle that detected the 8th rising edge.
  - mcu_dout holds its value until the next byte completes.
- Unknown target id (not one of the four):
  - Bytes are still counted and the state advances.
  - No strobe is issued and MISO returns 8'h00.
- Reply path:
  - On the first falling SCK edge after a byte completes, tx is loaded from the selected target's din instead of shifting, so the MSB is valid before the next rising edge.
  - The 8x clock-ratio rule guarantees the target has updated its reply (strobe +1 cycle) before this load.
  - In TARGET, and on the falling edge after the target byte, tx loads 8'h00.
  - Net effect: the reply to byte N is shifted during byte N+1.
- Bit counter wraps 7 -> 0 at byte completion. Transactions have no length limit.
- Simultaneous SS deassertion and byte completion in the same clk: SS wins, and no strobe is issued.
- Reset mid-transaction: all state and outputs return to reset values in the next cycle. The transfer restarts only on a fresh SS low edge.

Test Plan:
1. SS low, bytes 0x00, 0x01, 0x03, SS high -> one mcu_sys_strobe with mcu_start = 1 and mcu_dout = 0x01, then one with mcu_start = 0 and mcu_dout = 0x03. No other strobes fire.
2. Target 0x00, command 0x00, three dummy bytes, with a model target that replies 0x00 on start, then 0x5C, 0x42 -> MISO bytes are 00, 00, 00, 5C, 42.
3. Target 0x07, then 4 bytes -> no strobes at all and MISO constant 0. A following transaction to target 0x01 strobes HID only.
4. SS deasserted after 5 bits of the command byte, then a new transaction 0x02, 0xAA -> no strobe from the aborted byte. The OSD strobe fires with start = 1 and mcu_dout = 0xAA.
5. reset pulsed during the 3rd byte -> all outputs 0 next cycle. Remaining SCK edges produce no strobes until SS goes high and then low again.
6. Sweep the clk:SCK ratio across 8, 9 and 16, with SCK phase randomised relative to clk -> byte 0x5A and its reply 0xA5 are transferred without error at every ratio.
